// File: rtl/fpu8_exception_responder.sv
// FPU8 exception responder: one-entry result buffer with NaN substitution, sticky status, counter, IRQ.
// Latency: one cycle from accept to RES_VALID/RESULT; STATUS, EXC_COUNT and IRQ update on the same edge.
// Backpressure: REQ_READY = !RES_VALID | RES_READY, so it streams one op per cycle while downstream is ready.
`ifndef _NAN
`define _NAN 8'hFF
`endif
`ifndef _PLUS_INF
`define _PLUS_INF 8'h78
`endif
`ifndef _ADDITION
`define _ADDITION 2'b00
`endif
`ifndef _SUBTRACTION
`define _SUBTRACTION 2'b01
`endif
`ifndef _MULTIPLICATION
`define _MULTIPLICATION 2'b10
`endif

module fpu8_exception_responder #(
  parameter int COUNT_W = 8,
  parameter bit IRQ_EN  = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic [1:0]         FP_OPERATION,
  input  logic [7:0]         OP_A,
  input  logic [7:0]         OP_B,
  input  logic               OP_IS_EXCEPTION,
  input  logic [7:0]         RAW_RESULT,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [7:0]         RESULT,
  output logic               RESULT_IS_EXC,
  output logic [3:0]         STATUS,
  input  logic               STATUS_CLR,
  output logic [COUNT_W-1:0] EXC_COUNT,
  output logic               IRQ,
  input  logic               IRQ_ACK
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t state, next_state;

  logic               accept;
  logic               exc_accept;
  logic [3:0]         status_set;
  logic [3:0]         status_next;
  logic [COUNT_W-1:0] count_base;
  logic [COUNT_W-1:0] count_next;

  assign RES_VALID  = (state == FULL);
  assign REQ_READY  = !RES_VALID || RES_READY;
  assign accept     = REQ_VALID && REQ_READY;
  assign exc_accept = accept && OP_IS_EXCEPTION;

  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (accept) next_state = FULL;
      FULL:    if (RES_READY && !accept) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

  always_comb begin
    status_set = 4'b0000;
    case (FP_OPERATION)
      `_ADDITION:       status_set[0] = 1'b1;
      `_SUBTRACTION:    status_set[1] = 1'b1;
      `_MULTIPLICATION: status_set[2] = 1'b1;
      default:          ;
    endcase
    status_set[3] = (OP_A == `_NAN) || (OP_B == `_NAN);
  end

  // A clear in the same cycle as an exception wipes old state before the new event is recorded.
  always_comb begin
    status_next = STATUS_CLR ? 4'b0000 : STATUS;
    count_base  = STATUS_CLR ? '0 : EXC_COUNT;
    count_next  = count_base;
    if (exc_accept) begin
      status_next = status_next | status_set;
      if (count_base != {COUNT_W{1'b1}})
        count_next = count_base + COUNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= EMPTY;
      RESULT        <= 8'h00;
      RESULT_IS_EXC <= 1'b0;
      STATUS        <= 4'b0000;
      EXC_COUNT     <= '0;
      IRQ           <= 1'b0;
    end else begin
      state     <= next_state;
      STATUS    <= status_next;
      EXC_COUNT <= count_next;
      if (accept) begin
        RESULT        <= OP_IS_EXCEPTION ? `_NAN : RAW_RESULT;
        RESULT_IS_EXC <= OP_IS_EXCEPTION;
      end
      // A new exception outranks the acknowledge.
      if (exc_accept && IRQ_EN)
        IRQ <= 1'b1;
      else if (IRQ_ACK)
        IRQ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu8_exception_responder.sv
// Directed bench for fpu8_exception_responder: default instance plus a COUNT_W=2, IRQ_EN=0 instance on shared inputs.
`ifndef _NAN
`define _NAN 8'hFF
`endif
`ifndef _PLUS_INF
`define _PLUS_INF 8'h78
`endif
`ifndef _ADDITION
`define _ADDITION 2'b00
`endif
`ifndef _SUBTRACTION
`define _SUBTRACTION 2'b01
`endif
`ifndef _MULTIPLICATION
`define _MULTIPLICATION 2'b10
`endif

module tb_fpu8_exception_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] fp_operation;
  logic [7:0] op_a, op_b, raw_result;
  logic       op_is_exception;
  logic       res_ready;
  logic       status_clr;
  logic       irq_ack;

  logic       req_ready, res_valid, result_is_exc, irq;
  logic [7:0] result;
  logic [3:0] status;
  logic [7:0] exc_count;

  logic       req_ready2, res_valid2, result_is_exc2, irq2;
  logic [7:0] result2;
  logic [3:0] status2;
  logic [1:0] exc_count2;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  fpu8_exception_responder dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .FP_OPERATION(fp_operation), .OP_A(op_a), .OP_B(op_b),
    .OP_IS_EXCEPTION(op_is_exception), .RAW_RESULT(raw_result),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RESULT(result),
    .RESULT_IS_EXC(result_is_exc), .STATUS(status), .STATUS_CLR(status_clr),
    .EXC_COUNT(exc_count), .IRQ(irq), .IRQ_ACK(irq_ack)
  );

  fpu8_exception_responder #(.COUNT_W(2), .IRQ_EN(1'b0)) dut_sat (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready2),
    .FP_OPERATION(fp_operation), .OP_A(op_a), .OP_B(op_b),
    .OP_IS_EXCEPTION(op_is_exception), .RAW_RESULT(raw_result),
    .RES_VALID(res_valid2), .RES_READY(res_ready), .RESULT(result2),
    .RESULT_IS_EXC(result_is_exc2), .STATUS(status2), .STATUS_CLR(status_clr),
    .EXC_COUNT(exc_count2), .IRQ(irq2), .IRQ_ACK(irq_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Apply inputs at the falling edge, then advance to 1 time unit past the next rising edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic exc, input logic [7:0] raw, input logic rr,
                      input logic clr, input logic ack);
    @(negedge clk);
    req_valid = v; fp_operation = op; op_a = a; op_b = b;
    op_is_exception = exc; raw_result = raw; res_ready = rr;
    status_clr = clr; irq_ack = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; fp_operation = 2'b00; op_a = 8'h00; op_b = 8'h00;
    op_is_exception = 1'b0; raw_result = 8'h00; res_ready = 1'b0; status_clr = 1'b0; irq_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_result", 32'(result), 32'h00);
    check("rst_result_is_exc", 32'(result_is_exc), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_exc_count", 32'(exc_count), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Plain addition, no exception.
    step(1'b1, `_ADDITION, 8'h38, 8'h30, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
    check("add_res_valid", 32'(res_valid), 32'd1);
    check("add_result", 32'(result), 32'h3C);
    check("add_is_exc", 32'(result_is_exc), 32'd0);
    check("add_status", 32'(status), 32'd0);
    check("add_irq", 32'(irq), 32'd0);
    check("add_count", 32'(exc_count), 32'd0);

    // inf - inf raises an exception, result is substituted.
    step(1'b1, `_SUBTRACTION, `_PLUS_INF, `_PLUS_INF, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("sub_result", 32'(result), 32'(`_NAN));
    check("sub_is_exc", 32'(result_is_exc), 32'd1);
    check("sub_status", 32'(status), 32'b0010);
    check("sub_count", 32'(exc_count), 32'd1);
    check("sub_irq", 32'(irq), 32'd1);
    check("sub_res_valid", 32'(res_valid), 32'd1);

    // Backpressure for three cycles with a pending request.
    @(negedge clk);
    req_valid = 1'b1; fp_operation = `_ADDITION; op_a = 8'h10; op_b = 8'h20;
    op_is_exception = 1'b0; raw_result = 8'h11; res_ready = 1'b0;
    #1;
    check("bp_req_ready_low", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_result_hold", 32'(result), 32'(`_NAN));
      check("bp_is_exc_hold", 32'(result_is_exc), 32'd1);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_new_result", 32'(result), 32'h11);
    check("bp_new_is_exc", 32'(result_is_exc), 32'd0);
    check("bp_stream_valid", 32'(res_valid), 32'd1);
    check("bp_status_kept", 32'(status), 32'b0010);
    check("bp_count_kept", 32'(exc_count), 32'd1);

    // Exception with clear and ack in the same cycle: clear first, set wins over ack.
    step(1'b1, `_MULTIPLICATION, `_NAN, 8'h20, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    check("clr_status", 32'(status), 32'b1100);
    check("clr_count", 32'(exc_count), 32'd1);
    check("clr_irq_set_wins", 32'(irq), 32'd1);
    check("clr_result", 32'(result), 32'(`_NAN));

    // Ack alone drops IRQ, leaves STATUS; buffer drains.
    step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("ack_irq", 32'(irq), 32'd0);
    check("ack_status", 32'(status), 32'b1100);
    check("drain_res_valid", 32'(res_valid), 32'd0);
    check("drain_result_hold", 32'(result), 32'(`_NAN));

    // Exception on an unlisted op code: no op bit, counted, IRQ raised.
    step(1'b1, 2'b11, 8'h01, 8'h02, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    check("other_status", 32'(status), 32'b1100);
    check("other_count", 32'(exc_count), 32'd2);
    check("other_irq", 32'(irq), 32'd1);

    // Clear alone does not touch IRQ.
    step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    check("clr_only_status", 32'(status), 32'd0);
    check("clr_only_count", 32'(exc_count), 32'd0);
    check("clr_only_irq", 32'(irq), 32'd1);

    // Reset with a held result and IRQ pending.
    step(1'b1, `_ADDITION, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    check("pre_rst_irq", 32'(irq), 32'd1);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; op_is_exception = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'h00);
    check("mid_rst_is_exc", 32'(result_is_exc), 32'd0);
    check("mid_rst_status", 32'(status), 32'd0);
    check("mid_rst_count", 32'(exc_count), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;

    // Saturation on the narrow counter; the IRQ-disabled instance never raises IRQ.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, `_ADDITION, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      check("sat_count_w2", 32'(exc_count2), (i < 3) ? 32'(i + 1) : 32'd3);
      check("sat_count_w8", 32'(exc_count), 32'(i + 1));
    end
    check("sat_irq_disabled", 32'(irq2), 32'd0);
    check("sat_status_w2", 32'(status2), 32'b0001);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
